// File: rtl/muxn_pipe_reg.sv
// muxn_pipe_reg: N-way source select captured into a pipeline register with
// stall/flush hazard control, valid tracking and a saturating stall counter.
// Optional build macro MUXN_SELERR_EN adds a sticky sel_err output.
module muxn_pipe_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   src,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  output logic [SEL_W-1:0]     out_sel,
  output logic [CNT_W-1:0]     stall_cnt
`ifdef MUXN_SELERR_EN
  ,
  output logic                 sel_err
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] pick_c;

  logic [WIDTH-1:0] out_q,   out_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Source select; selects beyond the last source read as zero.
  always_comb begin
    pick_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        pick_c = src[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state: flush beats stall beats load.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    if (flush) begin
      out_d   = '0;
      valid_d = 1'b0;
      sel_d   = '0;
      cnt_d   = '0;
    end else if (stall) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      out_d   = pick_c;
      valid_d = in_valid;
      sel_d   = sel;
      cnt_d   = '0;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign out_sel   = sel_q;
  assign stall_cnt = cnt_q;

`ifdef MUXN_SELERR_EN
  logic sel_oor_c;
  logic err_q, err_d;

  assign sel_oor_c = (32'(sel) >= N);

  // Sticky error: set by a valid load with an out-of-range select; only reset clears it.
  always_comb begin
    err_d = err_q;
    if (!flush && !stall && in_valid && sel_oor_c) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign sel_err = err_q;
`endif

endmodule

// File: tb/tb_muxn_pipe_reg.sv
// Bench for muxn_pipe_reg: an N=4 and an N=3 instance share stimulus, a
// behavioural model predicts every output each cycle, and directed literal
// expectations pin the model. Honors MUXN_SELERR_EN when defined.
module tb_muxn_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic        in_valid, stall, flush;
  logic [31:0] w [4];
  logic [127:0] src_a;
  logic [95:0]  src_b;

  logic [31:0] out_a, out_b;
  logic        v_a, v_b;
  logic [1:0]  sel_a, sel_b;
  logic [7:0]  cnt_a, cnt_b;
`ifdef MUXN_SELERR_EN
  logic        err_a, err_b;
`endif

  int checks = 0;
  int errors = 0;

  assign src_a = {w[3], w[2], w[1], w[0]};
  assign src_b = {w[2], w[1], w[0]};

  always #5 clk = ~clk;

  muxn_pipe_reg #(.WIDTH(32), .N(4), .SEL_W(2), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .src(src_a), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out_a), .out_valid(v_a),
    .out_sel(sel_a), .stall_cnt(cnt_a)
`ifdef MUXN_SELERR_EN
    , .sel_err(err_a)
`endif
  );

  muxn_pipe_reg #(.WIDTH(32), .N(3), .SEL_W(2), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .src(src_b), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out_b), .out_valid(v_b),
    .out_sel(sel_b), .stall_cnt(cnt_b)
`ifdef MUXN_SELERR_EN
    , .sel_err(err_b)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 is the 4-source stage, index 1 the 3-source stage.
  int          n_src [2] = '{4, 3};
  logic [31:0] m_out [2];
  logic        m_v   [2];
  logic [1:0]  m_sel [2];
  int          m_cnt [2];
  logic        m_err [2];
  bit          model_ok = 0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_out[d] = 0; m_v[d] = 0; m_sel[d] = 0; m_cnt[d] = 0; m_err[d] = 0;
      end else if (flush) begin
        m_out[d] = 0; m_v[d] = 0; m_sel[d] = 0; m_cnt[d] = 0;
      end else if (stall) begin
        m_cnt[d] = (m_cnt[d] + 1 > 255) ? 255 : m_cnt[d] + 1;
      end else begin
        m_out[d] = (int'(sel) < n_src[d]) ? w[sel] : 32'h0;
        m_v[d]   = in_valid;
        m_sel[d] = sel;
        m_cnt[d] = 0;
        if (in_valid && int'(sel) >= n_src[d]) m_err[d] = 1;
      end
    end
    if (reset) model_ok = 1;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("a_out", 64'(out_a), 64'(m_out[0]));
      chk("a_valid", 64'(v_a), 64'(m_v[0]));
      chk("a_sel", 64'(sel_a), 64'(m_sel[0]));
      chk("a_cnt", 64'(cnt_a), 64'(m_cnt[0]));
      chk("b_out", 64'(out_b), 64'(m_out[1]));
      chk("b_valid", 64'(v_b), 64'(m_v[1]));
      chk("b_sel", 64'(sel_b), 64'(m_sel[1]));
      chk("b_cnt", 64'(cnt_b), 64'(m_cnt[1]));
`ifdef MUXN_SELERR_EN
      chk("a_err", 64'(err_a), 64'(m_err[0]));
      chk("b_err", 64'(err_b), 64'(m_err[1]));
`endif
    end
  end

  // Drive inputs for one edge, then settle just after the following falling edge.
  task automatic step(input logic [1:0] s, input logic iv, input logic st,
                      input logic fl, input logic rs);
    sel = s; in_valid = iv; stall = st; flush = fl; reset = rs;
    @(negedge clk);
    #1;
  endtask

  task automatic restore_src();
    w[0] = 32'hAAAA0000; w[1] = 32'hBBBB0001;
    w[2] = 32'hCCCC0002; w[3] = 32'hDDDD0003;
  endtask

  initial begin
    restore_src();
    // Reset state
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_out", 64'(out_a), 64'h0);
    chk("rst_valid", 64'(v_a), 64'h0);
    chk("rst_cnt", 64'(cnt_a), 64'h0);

    // Plain load
    step(2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("load_out", 64'(out_a), 64'hCCCC0002);
    chk("load_valid", 64'(v_a), 64'h1);
    chk("load_sel", 64'(sel_a), 64'h2);
    chk("load_cnt", 64'(cnt_a), 64'h0);

    // Long stall with changing inputs: hold data, counter saturates
    for (int i = 0; i < 300; i++) begin
      w[0] = 32'(i);
      w[3] = ~32'(i);
      step(2'(i), i[0], 1'b1, 1'b0, 1'b0);
      if (i == 0)   chk("stall_cnt1", 64'(cnt_a), 64'd1);
      if (i == 254) chk("stall_cnt255", 64'(cnt_a), 64'd255);
      if (i == 299) begin
        chk("stall_sat", 64'(cnt_a), 64'd255);
        chk("stall_out", 64'(out_a), 64'hCCCC0002);
        chk("stall_valid", 64'(v_a), 64'h1);
        chk("stall_sel", 64'(sel_a), 64'h2);
      end
    end
    restore_src();
    step(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("unstall_out", 64'(out_a), 64'hBBBB0001);
    chk("unstall_cnt", 64'(cnt_a), 64'h0);

    // Flush wins over a simultaneous stall
    step(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step(2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_out", 64'(out_a), 64'h0);
    chk("flush_valid", 64'(v_a), 64'h0);
    chk("flush_sel", 64'(sel_a), 64'h0);
    chk("flush_cnt", 64'(cnt_a), 64'h0);

    // Reset in the middle of a stall
    w[0] = 32'h12345678;
    step(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) step(2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_out", 64'(out_a), 64'h12345678);
    chk("pre_rst_cnt", 64'(cnt_a), 64'd5);
    step(2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("mid_rst_out", 64'(out_a), 64'h0);
    chk("mid_rst_valid", 64'(v_a), 64'h0);
    chk("mid_rst_cnt", 64'(cnt_a), 64'h0);
    restore_src();
    step(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_out", 64'(out_a), 64'hBBBB0001);
    chk("post_rst_valid", 64'(v_a), 64'h1);

    // Out-of-range select on the 3-source stage
    step(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sel3_a_out", 64'(out_a), 64'hDDDD0003);
    chk("oor_out", 64'(out_b), 64'h0);
    chk("oor_valid", 64'(v_b), 64'h1);
    chk("oor_sel", 64'(sel_b), 64'h3);
`ifdef MUXN_SELERR_EN
    chk("oor_err_b", 64'(err_b), 64'h1);
    chk("oor_err_a", 64'(err_a), 64'h0);
`endif
    step(2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("oor_flush_valid", 64'(v_b), 64'h0);
`ifdef MUXN_SELERR_EN
    chk("err_sticky", 64'(err_b), 64'h1);
`endif
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef MUXN_SELERR_EN
    chk("err_rst", 64'(err_b), 64'h0);
`endif

    // Invalid capture still loads data
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("inv_out", 64'(out_a), 64'hAAAA0000);
    chk("inv_valid", 64'(v_a), 64'h0);
    chk("inv_out_b", 64'(out_b), 64'hAAAA0000);

    step(2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'd1, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muxn_pipe_reg.md
Name: muxn_pipe_reg

Overview:
- Parametrised N-way select feeding a pipeline register with stall, flush and valid tracking.
- Generalises the 2:1 combinational select into a registered stage: selects one of N sources, captures it at the clock edge, and holds or bubbles it under hazard control.
- Sits at pipeline-stage boundaries in the CPU datapath, for example a forwarded operand feeding the D/E or E/M register.
- Also keeps a saturating count of consecutive stall cycles for hazard-unit debug.

Parameters:
- WIDTH, 32, data width of each source and of the output.
- N, 4, number of sources; legal range 2..16.
- SEL_W, 2, select width; must be at least clog2(N).
- CNT_W, 8, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- src  input  N*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  source select.
- in_valid  input  1  the upstream stage holds a real instruction.
- stall  input  1  hold the current register contents.
- flush  input  1  replace the current contents with a bubble.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  registered valid.
- out_sel  output  SEL_W  registered copy of the select used for the current contents.
- stall_cnt  output  CNT_W  consecutive-stall counter.

Behaviour:
- Synchronous, active-high reset; the clock is clk. All state changes only on the rising clk edge.
- Combinational pick: pick = src[sel*WIDTH +: WIDTH] when sel < N; pick = 0 when sel >= N.
- Priority at each edge is reset > flush > stall > load.
  - reset: out=0, out_valid=0, out_sel=0, stall_cnt=0.
  - flush: out=0, out_valid=0, out_sel=0, stall_cnt=0. Flush wins over a simultaneous stall.
  - stall (no flush): out, out_valid and out_sel hold. stall_cnt increments and saturates at 2^CNT_W-1 (no wrap).
  - load (none of the above): out=pick, out_valid=in_valid, out_sel=sel, stall_cnt=0.
- Latency: exactly one cycle from src/sel/in_valid to out/out_valid.
- There is no combinational path from any input to any output.
- in_valid=0 on a load still captures pick into out. Consumers qualify out with out_valid.
- Reset asserted mid-stall clears everything. The first non-reset, non-stall edge loads normally.
- The stage always loads when not stalled: no backpressure, no internal buffering beyond the single register.
- Widths: src is exactly N*WIDTH bits. No sign or zero extension is applied to the data.

Optional Feature:
- Macro: MUXN_SELERR_EN.
- Defined: adds output sel_err (1 bit, reset 0).
  - sel_err sets sticky on any load edge with in_valid=1 and sel >= N.
  - It is cleared only by reset; flush does not clear it.
  - The out value in that case is still 0.
- Undefined: no sel_err port and no associated logic. Out-of-range selects silently produce 0.

Test Plan:
- Load: WIDTH=32, N=4, src={k3=0xDDDD0003, k2=0xCCCC0002, k1=0xBBBB0001, k0=0xAAAA0000}, sel=2, in_valid=1, one edge -> out=0xCCCC0002, out_valid=1, out_sel=2, stall_cnt=0.
- Stall hold and saturation: after the load, stall=1 for 300 cycles while src and sel change -> out stays 0xCCCC0002, out_valid=1, stall_cnt reads 1,2,...,255 and then holds 255. Drop stall -> next edge loads the new pick, stall_cnt=0.
- Flush vs stall: stall=1 and flush=1 on the same edge -> out=0, out_valid=0, out_sel=0, stall_cnt=0.
- Reset mid-operation: out=0x12345678 valid with stall_cnt=5, assert reset for one edge -> all outputs 0. Next edge with sel=1, in_valid=1 -> out=0xBBBB0001.
- Non-power-of-2 N: N=3, SEL_W=2, sel=3, in_valid=1 -> out=0, out_valid=1, out_sel=3. With MUXN_SELERR_EN defined, sel_err=1 and stays 1 through a subsequent flush until reset.
- Invalid capture: in_valid=0, sel=0 -> out=0xAAAA0000, out_valid=0.
